id_ex: RTL and testbench
========================

Name: id_ex

Overview:
- Pipeline register between the decode stage (id) and the execute stage (ex) of the 5-stage RV32I core.
- Captures the decoded instruction, its address, both operands, the destination register and the write enable from id, and presents them to ex one cycle later.
- Uses a valid/ready handshake with a one-entry skid buffer, so an ex-side stall never drops an instruction and ready_o is driven straight from a flop.
- ctrl can flush it on a taken branch or jump; a flushed slot becomes a NOP bubble.

Parameters:
- DW, 32, width of instruction, address and operand fields
- NOP_INST, 32'h0000_0013, instruction driven on a bubble (addi x0,x0,0)

Ports:
- clk  in  1  core clock, all flops rising-edge
- rst_n  in  1  asynchronous reset, active-low
- inst_i  in  DW  instruction word from id
- inst_addr_i  in  DW  PC of the instruction from id
- op1_i  in  DW  operand 1 from id
- op2_i  in  DW  operand 2 from id
- rd_addr_i  in  5  destination register from id
- reg_wen_i  in  1  register write enable from id
- valid_i  in  1  id presents a valid instruction
- ready_o  out  1  id_ex can accept this cycle
- flush_i  in  1  ctrl flush (taken branch or jump)
- inst_o  out  DW  instruction to ex
- inst_addr_o  out  DW  PC to ex
- op1_o  out  DW  operand 1 to ex
- op2_o  out  DW  operand 2 to ex
- rd_addr_o  out  5  destination register to ex
- reg_wen_o  out  1  write enable to ex
- valid_o  out  1  ex-side payload is valid
- ready_i  in  1  ex consumes the payload this cycle

Behaviour:
- Reset: rst_n low clears state asynchronously to EMPTY. On reset, inst_o=NOP_INST; inst_addr_o, op1_o, op2_o=0; rd_addr_o=0; reg_wen_o=0; valid_o=0; ready_o=1. Reset mid-transfer discards all held entries.
- Storage: main entry M drives the outputs; skid entry S holds one overflow instruction.
- Transfers: accept = valid_i & ready_o; consume = valid_o & ready_i.
- State machine:
  - EMPTY: on accept, load M and go to FULL.
  - FULL, consume with no accept: go to EMPTY.
  - FULL, consume and accept: reload M from the inputs and stay FULL.
  - FULL, accept with no consume: load S and go to SKID.
  - SKID, on consume: move S to M and go to FULL.
  - SKID: ready_o=0, so no accept is possible.
- ready_o: a registered flop, equal to (next state != SKID). It is not combinational from ready_i.
- Latency: 1 cycle from accept to valid_o when EMPTY. Throughput is 1 per cycle while ready_i=1.
- Bubble output: whenever valid_o=0, outputs are forced to the reset values above (NOP_INST, zeros, reg_wen_o=0). Stale payload never reaches ex.
- Flush:
  - flush_i=1 forces the next state to EMPTY, invalidates M and S, and drops any accept in the same cycle.
  - ready_o=1 in the following cycle.
  - Flush has priority over accept and consume.
  - A consume in the flush cycle still completes, because ex sampled it that cycle.
- Hold: while valid_o=1 and ready_i=0, every output stays bit-stable.
- No data-path arithmetic. Fields are copied bit-exact.
- rd_addr_i=0 passes through unchanged. Masking x0 writes is the job of regs.

Optional Feature:
- Macro: IDEX_PERF_CNT_EN.
- When defined:
  - Adds output ports stall_cnt_o (32) and flush_cnt_o (32).
  - stall_cnt_o increments each cycle with valid_o=1 and ready_i=0.
  - flush_cnt_o increments each cycle with flush_i=1.
  - Both counters wrap at 2^32 to 0, and both reset to 0 on rst_n low.
  - Flush does not clear them.
- When undefined: the ports and counters are absent, and the core behaviour is identical.

Test Plan:
- Reset then idle: rst_n low for 3 cycles, release -> valid_o=0, inst_o=32'h0000_0013, ready_o=1, reg_wen_o=0.
- Streaming: ready_i=1; send addi x1,x0,5 (32'h0050_0093, PC 0x0) then add x3,x1,x2 (32'h0020_81B3, PC 0x4) on consecutive cycles -> each appears one cycle later with valid_o=1, no gap, and op1/op2/rd_addr match.
- Skid:
  - ready_i=0 while two instructions are sent back-to-back -> both are accepted, ready_o goes 0 after the second, and outputs hold the first.
  - Raise ready_i -> the first is consumed, then the second, in order, and ready_o returns to 1.
- Flush in SKID state with valid_i=1 -> next cycle valid_o=0, inst_o=NOP, ready_o=1; the flushed and incoming instructions never appear.
- Async reset mid-stream: drop rst_n between clock edges while FULL -> outputs reach reset values immediately, without waiting for clk.
- Perf counters (IDEX_PERF_CNT_EN): 4 stall cycles and 2 flush pulses -> stall_cnt_o=4, flush_cnt_o=2. Preload the counter to 32'hFFFF_FFFF, stall once -> stall_cnt_o=0.

Source files
------------

// File: rtl/id_ex.sv
// id/ex pipeline register: valid/ready handshake, one-entry skid buffer, flush to NOP bubble.
// Optional IDEX_PERF_CNT_EN adds stall and flush event counters.
module id_ex #(
    parameter int            DW       = 32,
    parameter logic [DW-1:0] NOP_INST = 32'h0000_0013
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [DW-1:0] inst_i,
    input  logic [DW-1:0] inst_addr_i,
    input  logic [DW-1:0] op1_i,
    input  logic [DW-1:0] op2_i,
    input  logic [4:0]    rd_addr_i,
    input  logic          reg_wen_i,
    input  logic          valid_i,
    output logic          ready_o,
    input  logic          flush_i,
    output logic [DW-1:0] inst_o,
    output logic [DW-1:0] inst_addr_o,
    output logic [DW-1:0] op1_o,
    output logic [DW-1:0] op2_o,
    output logic [4:0]    rd_addr_o,
    output logic          reg_wen_o,
    output logic          valid_o,
    input  logic          ready_i
`ifdef IDEX_PERF_CNT_EN
    ,
    output logic [31:0]   stall_cnt_o,
    output logic [31:0]   flush_cnt_o
`endif
);

    // state | meaning
    // EMPTY | no entry held, outputs show the NOP bubble
    // FULL  | M holds the instruction presented to ex
    // SKID  | M presented, S holds one overflow entry, ready_o low
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FULL  = 2'd1,
        ST_SKID  = 2'd2
    } state_t;

    localparam int PW = 4*DW + 6;

    state_t        r_state;
    state_t        w_state_nxt;
    logic          r_ready;
    logic [PW-1:0] r_m_pl;
    logic [PW-1:0] r_s_pl;
    logic [PW-1:0] w_in_pl;
    logic          w_valid;
    logic          w_accept;
    logic          w_consume;

    assign w_in_pl   = {inst_i, inst_addr_i, op1_i, op2_i, rd_addr_i, reg_wen_i};
    assign w_valid   = (r_state != ST_EMPTY);
    assign w_accept  = valid_i & r_ready;
    assign w_consume = w_valid & ready_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_EMPTY;
            r_ready <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            r_ready <= (w_state_nxt != ST_SKID);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (flush_i) begin
            w_state_nxt = ST_EMPTY;
        end else begin
            case (r_state)
                ST_EMPTY: if (w_accept) w_state_nxt = ST_FULL;
                ST_FULL: begin
                    if (w_consume && !w_accept)      w_state_nxt = ST_EMPTY;
                    else if (!w_consume && w_accept) w_state_nxt = ST_SKID;
                end
                ST_SKID:  if (w_consume) w_state_nxt = ST_FULL;
                default:  w_state_nxt = ST_EMPTY;
            endcase
        end
    end

    // Payload flops; a flush leaves them untouched since the EMPTY state hides them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_m_pl <= '0;
            r_s_pl <= '0;
        end else if (!flush_i) begin
            case (r_state)
                ST_EMPTY: if (w_accept) r_m_pl <= w_in_pl;
                ST_FULL: begin
                    if (w_accept && w_consume)  r_m_pl <= w_in_pl;
                    if (w_accept && !w_consume) r_s_pl <= w_in_pl;
                end
                ST_SKID:  if (w_consume) r_m_pl <= r_s_pl;
                default: ;
            endcase
        end
    end

    always_comb begin
        valid_o     = w_valid;
        ready_o     = r_ready;
        inst_o      = NOP_INST;
        inst_addr_o = '0;
        op1_o       = '0;
        op2_o       = '0;
        rd_addr_o   = '0;
        reg_wen_o   = 1'b0;
        if (w_valid) begin
            {inst_o, inst_addr_o, op1_o, op2_o, rd_addr_o, reg_wen_o} = r_m_pl;
        end
    end

`ifdef IDEX_PERF_CNT_EN
    logic [31:0] r_stall_cnt;
    logic [31:0] r_flush_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (w_valid && !ready_i) r_stall_cnt <= r_stall_cnt + 32'd1;
            if (flush_i)             r_flush_cnt <= r_flush_cnt + 32'd1;
        end
    end

    assign stall_cnt_o = r_stall_cnt;
    assign flush_cnt_o = r_flush_cnt;
`endif

endmodule

// File: tb/tb_id_ex.sv
// Directed self-checking bench for id_ex; inputs change and outputs are sampled on the falling edge.
module tb_id_ex;
    localparam int DW = 32;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic          clk;
    logic          rst_n;
    logic [DW-1:0] inst_i, inst_addr_i, op1_i, op2_i;
    logic [4:0]    rd_addr_i;
    logic          reg_wen_i, valid_i, ready_o, flush_i;
    logic [DW-1:0] inst_o, inst_addr_o, op1_o, op2_o;
    logic [4:0]    rd_addr_o;
    logic          reg_wen_o, valid_o, ready_i;
`ifdef IDEX_PERF_CNT_EN
    logic [31:0]   stall_cnt_o, flush_cnt_o;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    id_ex #(.DW(DW), .NOP_INST(NOP)) dut (
        .clk(clk), .rst_n(rst_n),
        .inst_i(inst_i), .inst_addr_i(inst_addr_i), .op1_i(op1_i), .op2_i(op2_i),
        .rd_addr_i(rd_addr_i), .reg_wen_i(reg_wen_i), .valid_i(valid_i), .ready_o(ready_o),
        .flush_i(flush_i),
        .inst_o(inst_o), .inst_addr_o(inst_addr_o), .op1_o(op1_o), .op2_o(op2_o),
        .rd_addr_o(rd_addr_o), .reg_wen_o(reg_wen_o), .valid_o(valid_o), .ready_i(ready_i)
`ifdef IDEX_PERF_CNT_EN
        , .stall_cnt_o(stall_cnt_o), .flush_cnt_o(flush_cnt_o)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive(input logic v, input logic [31:0] inst, input logic [31:0] pc,
                         input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd,
                         input logic wen);
        valid_i = v; inst_i = inst; inst_addr_i = pc; op1_i = a; op2_i = b;
        rd_addr_i = rd; reg_wen_i = wen;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; ready_i = 1'b0; flush_i = 1'b0;
        drive(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_tests++; if (valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %0b want 0", valid_o); end
        n_tests++; if (inst_o !== NOP) begin n_fail++; $display("FAIL reset_inst: got %h want %h", inst_o, NOP); end
        n_tests++; if (ready_o !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %0b want 1", ready_o); end
        n_tests++; if (reg_wen_o !== 1'b0) begin n_fail++; $display("FAIL reset_wen: got %0b want 0", reg_wen_o); end
        n_tests++; if (inst_addr_o !== 32'h0) begin n_fail++; $display("FAIL reset_addr: got %h want 0", inst_addr_o); end
    endtask

    task automatic test_streaming();
        ready_i = 1'b1;
        drive(1'b1, 32'h0050_0093, 32'h0, 32'h0, 32'h5, 5'd1, 1'b1);
        @(negedge clk);
        n_tests++; if (valid_o !== 1'b1) begin n_fail++; $display("FAIL stream_valid0: got %0b want 1", valid_o); end
        n_tests++; if (inst_o !== 32'h0050_0093) begin n_fail++; $display("FAIL stream_inst0: got %h want 00500093", inst_o); end
        n_tests++; if (op2_o !== 32'h5) begin n_fail++; $display("FAIL stream_op2_0: got %h want 5", op2_o); end
        n_tests++; if (rd_addr_o !== 5'd1) begin n_fail++; $display("FAIL stream_rd0: got %0d want 1", rd_addr_o); end
        drive(1'b1, 32'h0020_81B3, 32'h4, 32'h5, 32'h7, 5'd3, 1'b1);
        @(negedge clk);
        n_tests++; if (valid_o !== 1'b1) begin n_fail++; $display("FAIL stream_valid1: got %0b want 1", valid_o); end
        n_tests++; if (inst_o !== 32'h0020_81B3) begin n_fail++; $display("FAIL stream_inst1: got %h want 002081b3", inst_o); end
        n_tests++; if (inst_addr_o !== 32'h4) begin n_fail++; $display("FAIL stream_pc1: got %h want 4", inst_addr_o); end
        n_tests++; if (op1_o !== 32'h5) begin n_fail++; $display("FAIL stream_op1_1: got %h want 5", op1_o); end
        n_tests++; if (op2_o !== 32'h7) begin n_fail++; $display("FAIL stream_op2_1: got %h want 7", op2_o); end
        n_tests++; if (rd_addr_o !== 5'd3) begin n_fail++; $display("FAIL stream_rd1: got %0d want 3", rd_addr_o); end
        n_tests++; if (ready_o !== 1'b1) begin n_fail++; $display("FAIL stream_ready: got %0b want 1", ready_o); end
        drive(1'b0, 32'hDEAD_BEEF, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0);
        @(negedge clk);
        n_tests++; if (valid_o !== 1'b0) begin n_fail++; $display("FAIL stream_drain_valid: got %0b want 0", valid_o); end
        n_tests++; if (inst_o !== NOP || op1_o !== 32'h0) begin n_fail++; $display("FAIL stream_bubble: got %h/%h want %h/0", inst_o, op1_o, NOP); end
    endtask

    task automatic test_skid();
        ready_i = 1'b0;
        drive(1'b1, 32'h0010_0113, 32'h8, 32'h11, 32'h22, 5'd2, 1'b1);
        @(negedge clk);
        n_tests++; if (ready_o !== 1'b1) begin n_fail++; $display("FAIL skid_ready_first: got %0b want 1", ready_o); end
        drive(1'b1, 32'h0020_0193, 32'hC, 32'h33, 32'h44, 5'd3, 1'b0);
        @(negedge clk);
        n_tests++; if (ready_o !== 1'b0) begin n_fail++; $display("FAIL skid_ready_low: got %0b want 0", ready_o); end
        n_tests++; if (inst_o !== 32'h0010_0113) begin n_fail++; $display("FAIL skid_hold_a: got %h want 00100113", inst_o); end
        drive(1'b1, 32'hBAD0_0013, 32'h10, 32'h55, 32'h66, 5'd4, 1'b1);
        @(negedge clk);
        n_tests++; if (inst_o !== 32'h0010_0113 || op1_o !== 32'h11 || valid_o !== 1'b1) begin n_fail++; $display("FAIL skid_hold_stable: got %h/%h/%0b want 00100113/11/1", inst_o, op1_o, valid_o); end
        drive(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0);
        ready_i = 1'b1;
        @(negedge clk);
        n_tests++; if (inst_o !== 32'h0020_0193 || inst_addr_o !== 32'hC) begin n_fail++; $display("FAIL skid_second: got %h@%h want 00200193@c", inst_o, inst_addr_o); end
        n_tests++; if (op2_o !== 32'h44 || reg_wen_o !== 1'b0) begin n_fail++; $display("FAIL skid_second_pl: got %h/%0b want 44/0", op2_o, reg_wen_o); end
        n_tests++; if (ready_o !== 1'b1) begin n_fail++; $display("FAIL skid_ready_back: got %0b want 1", ready_o); end
        @(negedge clk);
        n_tests++; if (valid_o !== 1'b0) begin n_fail++; $display("FAIL skid_no_third: got %0b want 0", valid_o); end
    endtask

    task automatic test_flush();
        ready_i = 1'b0;
        drive(1'b1, 32'h0030_0213, 32'h20, 32'h1, 32'h2, 5'd4, 1'b1);
        @(negedge clk);
        drive(1'b1, 32'h0040_0293, 32'h24, 32'h3, 32'h4, 5'd5, 1'b1);
        @(negedge clk);
        n_tests++; if (ready_o !== 1'b0) begin n_fail++; $display("FAIL flush_pre_skid: got %0b want 0", ready_o); end
        flush_i = 1'b1;
        drive(1'b1, 32'h0050_0313, 32'h28, 32'h5, 32'h6, 5'd6, 1'b1);
        @(negedge clk);
        n_tests++; if (valid_o !== 1'b0) begin n_fail++; $display("FAIL flush_valid: got %0b want 0", valid_o); end
        n_tests++; if (inst_o !== NOP) begin n_fail++; $display("FAIL flush_inst: got %h want %h", inst_o, NOP); end
        n_tests++; if (ready_o !== 1'b1) begin n_fail++; $display("FAIL flush_ready: got %0b want 1", ready_o); end
        // flush while EMPTY with an incoming instruction drops it
        flush_i = 1'b1;
        drive(1'b1, 32'h0060_0393, 32'h2C, 32'h7, 32'h8, 5'd7, 1'b1);
        @(negedge clk);
        flush_i = 1'b0;
        drive(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0);
        n_tests++; if (valid_o !== 1'b0) begin n_fail++; $display("FAIL flush_drop_accept: got %0b want 0", valid_o); end
        ready_i = 1'b1;
        @(negedge clk);
        n_tests++; if (valid_o !== 1'b0 || rd_addr_o !== 5'd0) begin n_fail++; $display("FAIL flush_no_reappear: got %0b/%0d want 0/0", valid_o, rd_addr_o); end
    endtask

    task automatic test_async_reset();
        ready_i = 1'b0;
        drive(1'b1, 32'h0070_0413, 32'h30, 32'h9, 32'hA, 5'd8, 1'b1);
        @(negedge clk);
        drive(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0);
        n_tests++; if (valid_o !== 1'b1) begin n_fail++; $display("FAIL areset_pre_full: got %0b want 1", valid_o); end
        #2 rst_n = 1'b0;
        #1;
        n_tests++; if (valid_o !== 1'b0 || inst_o !== NOP) begin n_fail++; $display("FAIL areset_immediate: got %0b/%h want 0/%h", valid_o, inst_o, NOP); end
        n_tests++; if (op1_o !== 32'h0 || reg_wen_o !== 1'b0 || ready_o !== 1'b1) begin n_fail++; $display("FAIL areset_fields: got %h/%0b/%0b want 0/0/1", op1_o, reg_wen_o, ready_o); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_tests++; if (valid_o !== 1'b0) begin n_fail++; $display("FAIL areset_after: got %0b want 0", valid_o); end
    endtask

`ifdef IDEX_PERF_CNT_EN
    task automatic test_perf();
        ready_i = 1'b0;
        drive(1'b1, 32'h0080_0493, 32'h40, 32'h1, 32'h1, 5'd9, 1'b1);
        @(negedge clk);
        drive(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0);
        repeat (4) @(negedge clk);
        ready_i = 1'b1;
        @(negedge clk);
        flush_i = 1'b1; @(negedge clk);
        flush_i = 1'b0; @(negedge clk);
        flush_i = 1'b1; @(negedge clk);
        flush_i = 1'b0;
        n_tests++; if (stall_cnt_o !== 32'd4) begin n_fail++; $display("FAIL perf_stall: got %0d want 4", stall_cnt_o); end
        n_tests++; if (flush_cnt_o !== 32'd2) begin n_fail++; $display("FAIL perf_flush: got %0d want 2", flush_cnt_o); end
        ready_i = 1'b0;
        drive(1'b1, 32'h0090_0513, 32'h44, 32'h2, 32'h2, 5'd10, 1'b1);
        @(negedge clk);
        drive(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0);
        dut.r_stall_cnt = 32'hFFFF_FFFF;
        @(negedge clk);
        n_tests++; if (stall_cnt_o !== 32'd0) begin n_fail++; $display("FAIL perf_wrap: got %h want 0", stall_cnt_o); end
        ready_i = 1'b1;
        @(negedge clk);
    endtask
`endif

    initial begin
        test_reset();
        test_streaming();
        test_skid();
        test_flush();
        test_async_reset();
`ifdef IDEX_PERF_CNT_EN
        test_perf();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
